cell_code_decoder: RTL and testbench

- Inverse of the 9-cell one-hot encoder. Accepts a 4-bit cell code (1..9; 0 = none) over a valid/ready handshake and decodes it to a registered 9-bit one-hot cell select.
- Tracks which cells have been claimed and rejects invalid or duplicate codes.
- Sits between the move-entry/encode path and the board display and win-check logic.

---
 rtl/cell_pkg.sv | 19 +
 rtl/cell_code_to_onehot.sv | 24 ++
 rtl/cell_code_decoder.sv | 134 +++++++++++++
 tb/tb_cell_code_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cell_pkg.sv
// Shared constants, state encoding and range helper for the cell code decoder.
// Optional feature macro used by the top: CELL_DEC_MOVE_COUNT_EN.
package cell_pkg;

    localparam int CELLS  = 9;
    localparam int CODE_W = 4;
    localparam logic [CODE_W-1:0] CODE_NONE = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_FULL
    } state_e;

    function automatic logic cell_in_range(input logic [CODE_W-1:0] code);
        return (code != CODE_NONE) && (code <= CODE_W'(CELLS));
    endfunction

endpackage

// File: rtl/cell_code_to_onehot.sv
// Combinational cell code to one-hot decode with an in-range flag.
// Shared with the display path, so it carries its own CELLS/CODE_W parameters.
module cell_code_to_onehot #(
    parameter int CELLS  = cell_pkg::CELLS,
    parameter int CODE_W = cell_pkg::CODE_W
) (
    input  logic [CODE_W-1:0] code,
    output logic [CELLS-1:0]  dec,
    output logic              valid
);

    localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(CELLS);
    localparam logic [CELLS-1:0]  ONE      = {{(CELLS-1){1'b0}}, 1'b1};

    // The shift is only evaluated in range, so code 0 can never wrap to the top bit.
    always_comb begin
        valid = (code != '0) && (code <= MAX_CODE);
        dec   = '0;
        if (valid) begin
            dec = ONE << (code - CODE_W'(1));
        end
    end

endmodule

// File: rtl/cell_code_decoder.sv
// Cell code decoder: accepts a code over valid/ready, checks it against the
// claimed-cell mask and registers the one-hot. Optional: CELL_DEC_MOVE_COUNT_EN.
//
// state   | meaning
// S_IDLE  | ready for a code
// S_CHECK | code_q captured; range/duplicate check, commit or refuse
// S_FULL  | every cell claimed; waits for clear
module cell_code_decoder
    import cell_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    output logic              code_ready,
    input  logic              clear,
    output logic [CELLS-1:0]  onehot,
    output logic [CELLS-1:0]  occupied,
    output logic              accept,
    output logic              reject,
    output logic              full
`ifdef CELL_DEC_MOVE_COUNT_EN
    ,
    output logic [CODE_W-1:0] move_count,
    output logic              reject_dup
`endif
);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q;
    logic [CELLS-1:0]  onehot_q, onehot_d;
    logic [CELLS-1:0]  occupied_q, occupied_d;
    logic              accept_q, accept_d;
    logic              reject_q, reject_d;
    logic [CELLS-1:0]  dec;
    logic              dec_valid;
    logic              xfer;

    cell_code_to_onehot #(
        .CELLS  (CELLS),
        .CODE_W (CODE_W)
    ) u_dec (
        .code  (code_q),
        .dec   (dec),
        .valid (dec_valid)
    );

    // clear gates ready so a code offered alongside clear is never taken.
    assign code_ready = (state_q == S_IDLE) && !clear;
    assign xfer       = code_valid && code_ready;
    assign full       = (state_q == S_FULL);
    assign onehot     = onehot_q;
    assign occupied   = occupied_q;
    assign accept     = accept_q;
    assign reject     = reject_q;

    always_comb begin
        state_d    = state_q;
        onehot_d   = onehot_q;
        occupied_d = occupied_q;
        accept_d   = 1'b0;
        reject_d   = 1'b0;
        if (clear) begin
            state_d    = S_IDLE;
            onehot_d   = '0;
            occupied_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (xfer) state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (dec_valid && ((occupied_q & dec) == '0)) begin
                        occupied_d = occupied_q | dec;
                        onehot_d   = dec;
                        accept_d   = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                    state_d = (&occupied_d) ? S_FULL : S_IDLE;
                end
                S_FULL: state_d = S_FULL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            code_q     <= CODE_NONE;
            onehot_q   <= '0;
            occupied_q <= '0;
            accept_q   <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            onehot_q   <= onehot_d;
            occupied_q <= occupied_d;
            accept_q   <= accept_d;
            reject_q   <= reject_d;
            if (xfer) code_q <= code;
        end
    end

`ifdef CELL_DEC_MOVE_COUNT_EN
    logic [CODE_W-1:0] count_q, count_d;
    logic              dup_q, dup_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (accept_d && (count_q < CODE_W'(CELLS))) begin
            count_d = count_q + CODE_W'(1);
        end
        dup_d = (state_q == S_CHECK) && !clear && dec_valid && ((occupied_q & dec) != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            dup_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dup_q   <= dup_d;
        end
    end

    assign move_count = count_q;
    assign reject_dup = dup_q;
`endif

endmodule

// File: tb/tb_cell_code_decoder.sv
// Directed, table-driven bench for cell_code_decoder plus corner-case sequences.
module tb_cell_code_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code_valid = 1'b0;
    logic [3:0] code = 4'd0;
    logic       code_ready;
    logic       clear = 1'b0;
    logic [8:0] onehot;
    logic [8:0] occupied;
    logic       accept;
    logic       reject;
    logic       full;
`ifdef CELL_DEC_MOVE_COUNT_EN
    logic [3:0] move_count;
    logic       reject_dup;
`endif

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    cell_code_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_valid (code_valid),
        .code       (code),
        .code_ready (code_ready),
        .clear      (clear),
        .onehot     (onehot),
        .occupied   (occupied),
        .accept     (accept),
        .reject     (reject),
        .full       (full)
`ifdef CELL_DEC_MOVE_COUNT_EN
        ,
        .move_count (move_count),
        .reject_dup (reject_dup)
`endif
    );

    typedef struct {
        logic [3:0] code;
        logic       acc;
        logic       rej;
        logic       dup;
        logic [8:0] oh;
        logic [8:0] occ;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] k);
        code_valid = 1'b1;
        code = k;
        tick();
        code_valid = 1'b0;
        tick();
    endtask

    task automatic chk_extra(input logic dup, input logic [3:0] cnt);
`ifdef CELL_DEC_MOVE_COUNT_EN
        chk("reject_dup", 32'(reject_dup), 32'(dup));
        chk("move_count", 32'(move_count), 32'(cnt));
`else
        if (dup === 1'bx || cnt === 4'bx) $display("unexpected unknown expectation");
`endif
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{4'd5,  1'b1, 1'b0, 1'b0, 9'h010, 9'h010, 4'd1};
        vecs[1] = '{4'd0,  1'b0, 1'b1, 1'b0, 9'h010, 9'h010, 4'd1};
        vecs[2] = '{4'd10, 1'b0, 1'b1, 1'b0, 9'h010, 9'h010, 4'd1};
        vecs[3] = '{4'd15, 1'b0, 1'b1, 1'b0, 9'h010, 9'h010, 4'd1};
        vecs[4] = '{4'd3,  1'b1, 1'b0, 1'b0, 9'h014, 9'h014, 4'd2};
        vecs[5] = '{4'd3,  1'b0, 1'b1, 1'b1, 9'h004, 9'h014, 4'd2};
        vecs[6] = '{4'd9,  1'b1, 1'b0, 1'b0, 9'h100, 9'h114, 4'd3};
        vecs[4].oh = 9'h004;

        #2;
        chk("rst_onehot", 32'(onehot), 32'h0);
        chk("rst_occupied", 32'(occupied), 32'h0);
        chk("rst_pulses", 32'({accept, reject, full}), 32'h0);
        #10 rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(code_ready), 32'h1);
        chk_extra(1'b0, 4'd0);

        for (int i = 0; i < 7; i++) begin
            code_valid = 1'b1;
            code = vecs[i].code;
            tick();
            code_valid = 1'b0;
            chk($sformatf("v%0d_ready_low", i), 32'(code_ready), 32'h0);
            chk($sformatf("v%0d_no_early", i), 32'({accept, reject}), 32'h0);
            tick();
            chk($sformatf("v%0d_accept", i), 32'(accept), 32'(vecs[i].acc));
            chk($sformatf("v%0d_reject", i), 32'(reject), 32'(vecs[i].rej));
            chk($sformatf("v%0d_onehot", i), 32'(onehot), 32'(vecs[i].oh));
            chk($sformatf("v%0d_occupied", i), 32'(occupied), 32'(vecs[i].occ));
            chk($sformatf("v%0d_full", i), 32'(full), 32'h0);
            chk_extra(vecs[i].dup, vecs[i].cnt);
            tick();
            chk($sformatf("v%0d_pulse_end", i), 32'({accept, reject}), 32'h0);
            chk($sformatf("v%0d_ready_back", i), 32'(code_ready), 32'h1);
        end

        // Fill the board from empty, then prove S_FULL ignores traffic until clear.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_occupied", 32'(occupied), 32'h0);
        for (int k = 1; k <= 9; k++) begin
            send(4'(k));
            chk($sformatf("fill%0d_accept", k), 32'(accept), 32'h1);
        end
        chk("fill_occupied", 32'(occupied), 32'h1FF);
        chk("fill_onehot", 32'(onehot), 32'h100);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_ready", 32'(code_ready), 32'h0);
        chk_extra(1'b0, 4'd9);
        code_valid = 1'b1;
        code = 4'd4;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("full_ignore_pulse", 32'({accept, reject}), 32'h0);
            chk("full_ignore_occ", 32'(occupied), 32'h1FF);
        end
        clear = 1'b1;
        #1;
        chk("clear_gates_ready", 32'(code_ready), 32'h0);
        tick();
        clear = 1'b0;
        code_valid = 1'b0;
        #1;
        chk("post_clear_occ", 32'(occupied), 32'h0);
        chk("post_clear_full", 32'(full), 32'h0);
        chk("post_clear_ready", 32'(code_ready), 32'h1);
        chk_extra(1'b0, 4'd0);
        tick();
        chk("post_clear_no_pulse", 32'({accept, reject}), 32'h0);

        // Clear during S_CHECK discards the pending code.
        code_valid = 1'b1;
        code = 4'd7;
        tick();
        code_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("chkclr_pulse", 32'({accept, reject}), 32'h0);
        chk("chkclr_occ", 32'(occupied), 32'h0);
        chk("chkclr_onehot", 32'(onehot), 32'h0);
        tick();
        chk("chkclr_later", 32'({accept, reject}), 32'h0);
        chk("chkclr_ready", 32'(code_ready), 32'h1);

        // Asynchronous reset mid-cycle, then the same code is accepted again.
        send(4'd2);
        chk("pre_rst_accept", 32'(accept), 32'h1);
        chk("pre_rst_occ", 32'(occupied), 32'h002);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_outputs", 32'({onehot, occupied, accept, reject, full}), 32'h0);
        #3 rst_n = 1'b1;
        tick();
        send(4'd2);
        chk("re_accept", 32'(accept), 32'h1);
        chk("re_occ", 32'(occupied), 32'h002);
        chk("re_onehot", 32'(onehot), 32'h002);
        chk_extra(1'b0, 4'd1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
